// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the fetch stage.
package imem_loader_pkg;

  localparam int unsigned INSN_W = 16;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    WAIT_SYNC = 3'd0,
    LEN_HI    = 3'd1,
    LEN_LO    = 3'd2,
    DATA_HI   = 3'd3,
    DATA_LO   = 3'd4,
    CSUM      = 3'd5,
    DONE      = 3'd6,
    ERR       = 3'd7
  } loader_state_t;

  // Running frame checksum: XOR of every byte following the sync marker.
  function automatic logic [7:0] csum_step(input logic [7:0] csum, input logic [7:0] data);
    return csum ^ data;
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Assembles a framed byte stream into 16-bit words, writes them into instruction
// memory from address 0 and holds the CPU in reset until a frame checks out.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [INSN_W-1:0] imem_wdata,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [2:0] ST_WAIT_SYNC = WAIT_SYNC;
  localparam logic [2:0] ST_LEN_HI    = LEN_HI;
  localparam logic [2:0] ST_LEN_LO    = LEN_LO;
  localparam logic [2:0] ST_DATA_HI   = DATA_HI;
  localparam logic [2:0] ST_DATA_LO   = DATA_LO;
  localparam logic [2:0] ST_CSUM      = CSUM;
  localparam logic [2:0] ST_DONE      = DONE;
  localparam logic [2:0] ST_ERR       = ERR;

  localparam logic [16:0]       DEPTH_LEN = 17'(1) << ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   WORDS_ONE = (ADDR_W + 1)'(1);

  logic [2:0]        state_r, state_nxt_s;
  logic [15:0]       len_r, len_nxt_s;
  logic [15:0]       len_in_s;
  logic [7:0]        hi_r, hi_nxt_s;
  logic [7:0]        csum_r, csum_nxt_s;
  logic [ADDR_W-1:0] addr_r, addr_nxt_s;
  logic [ADDR_W:0]   words_r, words_nxt_s;
  logic              we_r, we_nxt_s;
  logic [INSN_W-1:0] wdata_r, wdata_nxt_s;
  logic              ready_r;
  logic              cpu_rst_r, done_r, err_r;
  logic              take_s;
  logic              last_word_s;

  assign take_s      = rx_valid && ready_r;
  assign len_in_s    = {len_r[15:8], rx_data};
  assign last_word_s = ((17'(words_r) + 17'd1) == {1'b0, len_r});

  // Next-state and datapath decode, advanced only on an accepted byte.
  always_comb begin
    state_nxt_s = state_r;
    len_nxt_s   = len_r;
    hi_nxt_s    = hi_r;
    csum_nxt_s  = csum_r;
    addr_nxt_s  = addr_r;
    words_nxt_s = words_r;
    we_nxt_s    = 1'b0;
    wdata_nxt_s = wdata_r;

    // Address and count step once the write pulse has been presented.
    if (we_r) begin
      addr_nxt_s  = addr_r + ADDR_ONE;
      words_nxt_s = words_r + WORDS_ONE;
    end else begin
      addr_nxt_s  = addr_r;
      words_nxt_s = words_r;
    end

    if (take_s) begin
      case (state_r)
        ST_WAIT_SYNC, ST_DONE, ST_ERR: begin
          if (rx_data == SYNC_BYTE) begin
            state_nxt_s = ST_LEN_HI;
            csum_nxt_s  = 8'h00;
            addr_nxt_s  = '0;
            words_nxt_s = '0;
          end else begin
            state_nxt_s = state_r;
          end
        end
        ST_LEN_HI: begin
          len_nxt_s   = {rx_data, len_r[7:0]};
          csum_nxt_s  = csum_step(csum_r, rx_data);
          state_nxt_s = ST_LEN_LO;
        end
        ST_LEN_LO: begin
          len_nxt_s  = len_in_s;
          csum_nxt_s = csum_step(csum_r, rx_data);
          if ({1'b0, len_in_s} > DEPTH_LEN) begin
            state_nxt_s = ST_ERR;
          end else if (len_in_s == 16'd0) begin
            state_nxt_s = ST_CSUM;
          end else begin
            state_nxt_s = ST_DATA_HI;
          end
        end
        ST_DATA_HI: begin
          hi_nxt_s    = rx_data;
          csum_nxt_s  = csum_step(csum_r, rx_data);
          state_nxt_s = ST_DATA_LO;
        end
        ST_DATA_LO: begin
          csum_nxt_s  = csum_step(csum_r, rx_data);
          we_nxt_s    = 1'b1;
          wdata_nxt_s = {hi_r, rx_data};
          if (last_word_s) begin
            state_nxt_s = ST_CSUM;
          end else begin
            state_nxt_s = ST_DATA_HI;
          end
        end
        ST_CSUM: begin
          if (rx_data == csum_r) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_ERR;
          end
        end
        default: begin
          state_nxt_s = ST_WAIT_SYNC;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State, datapath and status registers; status flags follow the next state.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_r   <= ST_WAIT_SYNC;
      len_r     <= 16'h0000;
      hi_r      <= 8'h00;
      csum_r    <= 8'h00;
      addr_r    <= '0;
      words_r   <= '0;
      we_r      <= 1'b0;
      wdata_r   <= '0;
      ready_r   <= 1'b1;
      cpu_rst_r <= 1'b1;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      len_r     <= len_nxt_s;
      hi_r      <= hi_nxt_s;
      csum_r    <= csum_nxt_s;
      addr_r    <= addr_nxt_s;
      words_r   <= words_nxt_s;
      we_r      <= we_nxt_s;
      wdata_r   <= wdata_nxt_s;
      ready_r   <= 1'b1;
      cpu_rst_r <= (state_nxt_s != ST_DONE);
      done_r    <= (state_nxt_s == ST_DONE);
      err_r     <= (state_nxt_s == ST_ERR);
    end
  end

  assign rx_ready     = ready_r;
  assign imem_we      = we_r;
  assign imem_addr    = addr_r;
  assign imem_wdata   = wdata_r;
  assign cpu_rst      = cpu_rst_r;
  assign load_done    = done_r;
  assign load_err     = err_r;
  assign words_loaded = words_r;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader; expectations come from frame contents.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              CLK = 1'b0;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic              cpu_rst;
  logic              load_done;
  logic              load_err;
  logic [ADDR_W:0]   words_loaded;

  always #5 CLK = ~CLK;

  imem_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
    .CLK(CLK), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_rst(cpu_rst),
    .load_done(load_done), .load_err(load_err), .words_loaded(words_loaded)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  bit          gaps = 1'b0;
  logic [7:0]  tx_q[$];
  int          acc_q[$];
  logic [15:0] words_q[$];
  logic [55:0] wr_q[$];
  logic [55:0] exp_q[$];
  logic        rst_before_last;
  logic [1:0]  first_stat;

  always @(posedge CLK) cyc <= cyc + 1;

  // Record every write pulse as {addr, data, cycle}.
  always @(negedge CLK) begin
    if (imem_we === 1'b1) wr_q.push_back({imem_addr, imem_wdata, 32'(cyc)});
  end

  task automatic send_byte(input logic [7:0] b, output int acc);
    int tries;
    if (gaps && $urandom_range(0, 2) == 0) begin
      repeat ($urandom_range(1, 3)) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        @(negedge CLK);
      end
    end
    rx_data  = b;
    rx_valid = 1'b1;
    tries    = 0;
    while (rx_ready !== 1'b1 && tries < 20) begin
      @(negedge CLK);
      tries++;
    end
    if (rx_ready !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rx_ready_timeout: rx_ready=%b required 1", rx_ready);
    end
    @(negedge CLK);
    acc      = cyc;
    rx_valid = 1'b0;
  endtask

  // Frame: A5, LEN_HI, LEN_LO, words (hi,lo), XOR of all bytes after A5.
  task automatic build_frame(input int len_field, input bit corrupt);
    logic [7:0]  x;
    logic [15:0] lf;
    lf = 16'(len_field);
    tx_q = {};
    tx_q.push_back(8'hA5);
    tx_q.push_back(lf[15:8]);
    tx_q.push_back(lf[7:0]);
    if (len_field <= DEPTH) begin
      foreach (words_q[i]) begin
        tx_q.push_back(words_q[i][15:8]);
        tx_q.push_back(words_q[i][7:0]);
      end
      x = 8'h00;
      for (int i = 1; i < tx_q.size(); i++) x ^= tx_q[i];
      tx_q.push_back(corrupt ? (x ^ 8'h01) : x);
    end
  endtask

  // Drive the frame and derive expected writes: word i at address i, one cycle after its lo byte.
  task automatic run_frame(input int len_field);
    int a;
    wr_q  = {};
    exp_q = {};
    acc_q = {};
    foreach (tx_q[i]) begin
      if (i == tx_q.size() - 1) rst_before_last = cpu_rst;
      send_byte(tx_q[i], a);
      acc_q.push_back(a);
      if (i == 0) first_stat = {load_done, cpu_rst};
    end
    if (len_field <= DEPTH) begin
      foreach (words_q[i]) exp_q.push_back({8'(i), words_q[i], 32'(acc_q[4 + 2 * i])});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge CLK);
    n_cmp++; if (rx_ready !== 1'b1) begin n_bad++; $display("FAIL reset_rx_ready: got %b expected 1", rx_ready); end
    n_cmp++; if (imem_we !== 1'b0) begin n_bad++; $display("FAIL reset_imem_we: got %b expected 0", imem_we); end
    n_cmp++; if (imem_addr !== 8'h00) begin n_bad++; $display("FAIL reset_imem_addr: got %h expected 00", imem_addr); end
    n_cmp++; if (imem_wdata !== 16'h0000) begin n_bad++; $display("FAIL reset_imem_wdata: got %h expected 0000", imem_wdata); end
    n_cmp++; if (cpu_rst !== 1'b1) begin n_bad++; $display("FAIL reset_cpu_rst: got %b expected 1", cpu_rst); end
    n_cmp++; if (load_done !== 1'b0) begin n_bad++; $display("FAIL reset_load_done: got %b expected 0", load_done); end
    n_cmp++; if (load_err !== 1'b0) begin n_bad++; $display("FAIL reset_load_err: got %b expected 0", load_err); end
    n_cmp++; if (words_loaded !== 9'd0) begin n_bad++; $display("FAIL reset_words: got %0d expected 0", words_loaded); end
    rst = 1'b0;
  endtask

  task automatic load_fib();
    words_q = {16'h0000, 16'h5305, 16'h5101, 16'h5201, 16'h3400, 16'h1420,
               16'h1210, 16'h3100, 16'h1140, 16'h6301, 16'hD30A, 16'hFFFF};
  endtask

  task automatic test_fib();
    int a;
    gaps = 1'b0;
    wr_q = {};
    send_byte(8'h00, a); send_byte(8'hFF, a); send_byte(8'h13, a);
    n_cmp++; if ({load_done, load_err, cpu_rst, words_loaded, 32'(wr_q.size())} !== {3'b001, 9'd0, 32'd0}) begin
      n_bad++; $display("FAIL garbage_ignored: got done/err/rst/words %b%b%b/%0d writes %0d expected 001/0 writes 0",
                        load_done, load_err, cpu_rst, words_loaded, wr_q.size());
    end
    load_fib();
    build_frame(12, 1'b0);
    run_frame(12);
    n_cmp++; if (wr_q.size() != exp_q.size()) begin n_bad++; $display("FAIL fib_wr_count: got %0d expected %0d", wr_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < wr_q.size()) begin
      n_cmp++; if (wr_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL fib_write[%0d]: got addr_data_cyc %h expected %h", i, wr_q[i], exp_q[i]); end
    end
    n_cmp++; if (rst_before_last !== 1'b1) begin n_bad++; $display("FAIL fib_rst_held: got cpu_rst %b expected 1", rst_before_last); end
    n_cmp++; if ({load_done, load_err, cpu_rst, words_loaded} !== {3'b100, 9'd12}) begin
      n_bad++; $display("FAIL fib_status: got done/err/rst %b%b%b words %0d expected 100 words 12", load_done, load_err, cpu_rst, words_loaded);
    end
  endtask

  task automatic test_bad_csum();
    gaps = 1'b0;
    load_fib();
    build_frame(12, 1'b1);
    run_frame(12);
    n_cmp++; if (wr_q.size() != exp_q.size()) begin n_bad++; $display("FAIL badcsum_wr_count: got %0d expected %0d", wr_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < wr_q.size()) begin
      n_cmp++; if (wr_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL badcsum_write[%0d]: got %h expected %h", i, wr_q[i], exp_q[i]); end
    end
    n_cmp++; if ({load_done, load_err, cpu_rst, words_loaded} !== {3'b011, 9'd12}) begin
      n_bad++; $display("FAIL badcsum_status: got done/err/rst %b%b%b words %0d expected 011 words 12", load_done, load_err, cpu_rst, words_loaded);
    end
  endtask

  task automatic test_empty_oversize();
    gaps = 1'b0;
    words_q = {};
    build_frame(0, 1'b0);
    run_frame(0);
    n_cmp++; if ({load_done, load_err, cpu_rst, words_loaded, 32'(wr_q.size())} !== {3'b100, 9'd0, 32'd0}) begin
      n_bad++; $display("FAIL empty_status: got done/err/rst %b%b%b words %0d writes %0d expected 100 words 0 writes 0",
                        load_done, load_err, cpu_rst, words_loaded, wr_q.size());
    end
    build_frame(257, 1'b0);
    run_frame(257);
    n_cmp++; if ({load_done, load_err, cpu_rst, words_loaded, 32'(wr_q.size())} !== {3'b011, 9'd0, 32'd0}) begin
      n_bad++; $display("FAIL oversize_status: got done/err/rst %b%b%b words %0d writes %0d expected 011 words 0 writes 0",
                        load_done, load_err, cpu_rst, words_loaded, wr_q.size());
    end
  endtask

  task automatic test_random_gaps();
    int n;
    gaps = 1'b1;
    for (int it = 0; it < 3; it++) begin
      n = (it == 2) ? 165 : int'($urandom_range(1, 24));
      words_q = {};
      for (int k = 0; k < n; k++) words_q.push_back(16'($urandom));
      words_q[$urandom_range(0, n - 1)] = 16'h00A5;
      words_q[0] = 16'hA5A5;
      build_frame(n, 1'b0);
      run_frame(n);
      n_cmp++; if (wr_q.size() != exp_q.size()) begin n_bad++; $display("FAIL rand%0d_wr_count: got %0d expected %0d", it, wr_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < wr_q.size()) begin
        n_cmp++; if (wr_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL rand%0d_write[%0d]: got %h expected %h", it, i, wr_q[i], exp_q[i]); end
      end
      n_cmp++; if ({load_done, load_err, cpu_rst, words_loaded} !== {3'b100, 9'(n)}) begin
        n_bad++; $display("FAIL rand%0d_status: got done/err/rst %b%b%b words %0d expected 100 words %0d", it, load_done, load_err, cpu_rst, words_loaded, n);
      end
    end
    gaps = 1'b0;
  endtask

  task automatic test_reload();
    gaps = 1'b0;
    words_q = {16'h1234};
    build_frame(1, 1'b0);
    run_frame(1);
    n_cmp++; if (first_stat !== 2'b01) begin n_bad++; $display("FAIL reload_restart: got done/rst %b expected 01", first_stat); end
    n_cmp++; if (wr_q.size() != 1) begin n_bad++; $display("FAIL reload_wr_count: got %0d expected 1", wr_q.size()); end
    else begin
      n_cmp++; if (wr_q[0] !== exp_q[0]) begin n_bad++; $display("FAIL reload_write: got %h expected %h", wr_q[0], exp_q[0]); end
    end
    n_cmp++; if ({load_done, load_err, cpu_rst, words_loaded} !== {3'b100, 9'd1}) begin
      n_bad++; $display("FAIL reload_status: got done/err/rst %b%b%b words %0d expected 100 words 1", load_done, load_err, cpu_rst, words_loaded);
    end
  endtask

  task automatic test_reset_mid();
    int a;
    gaps = 1'b0;
    send_byte(8'hA5, a); send_byte(8'h00, a); send_byte(8'h05, a);
    send_byte(8'h77, a);
    rst = 1'b1;
    @(negedge CLK);
    rst = 1'b0;
    n_cmp++; if ({rx_ready, imem_we, imem_addr, imem_wdata, cpu_rst, load_done, load_err, words_loaded} !==
                 {1'b1, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 9'd0}) begin
      n_bad++; $display("FAIL midrst_values: got rdy %b we %b addr %h wdata %h rst %b done %b err %b words %0d",
                        rx_ready, imem_we, imem_addr, imem_wdata, cpu_rst, load_done, load_err, words_loaded);
    end
    words_q = {};
    for (int k = 0; k < 5; k++) words_q.push_back(16'($urandom));
    build_frame(5, 1'b0);
    run_frame(5);
    n_cmp++; if (wr_q.size() != exp_q.size()) begin n_bad++; $display("FAIL midrst_wr_count: got %0d expected %0d", wr_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < wr_q.size()) begin
      n_cmp++; if (wr_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL midrst_write[%0d]: got %h expected %h", i, wr_q[i], exp_q[i]); end
    end
    n_cmp++; if ({load_done, load_err, cpu_rst, words_loaded} !== {3'b100, 9'd5}) begin
      n_bad++; $display("FAIL midrst_status: got done/err/rst %b%b%b words %0d expected 100 words 5", load_done, load_err, cpu_rst, words_loaded);
    end
  endtask

  task automatic test_full();
    gaps = 1'b0;
    words_q = {};
    for (int k = 0; k < DEPTH; k++) words_q.push_back(16'($urandom));
    build_frame(DEPTH, 1'b0);
    run_frame(DEPTH);
    n_cmp++; if (wr_q.size() != exp_q.size()) begin n_bad++; $display("FAIL full_wr_count: got %0d expected %0d", wr_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < wr_q.size()) begin
      n_cmp++; if (wr_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL full_write[%0d]: got %h expected %h", i, wr_q[i], exp_q[i]); end
    end
    n_cmp++; if ({load_done, load_err, cpu_rst, words_loaded} !== {3'b100, 9'd256}) begin
      n_bad++; $display("FAIL full_status: got done/err/rst %b%b%b words %0d expected 100 words 256", load_done, load_err, cpu_rst, words_loaded);
    end
  endtask

  initial begin
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    @(negedge CLK);
    test_reset();
    test_fib();
    test_bad_csum();
    test_empty_oversize();
    test_random_gaps();
    test_reload();
    test_reset_mid();
    test_full();
    repeat (2) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
